uart_image_tx_sequencer: RTL and testbench

//  Streams one stored image frame out through the UART byte transmitter. On start, reads pixels from a

---
 rtl/uart_image_tx_sequencer_pkg.sv | 17 +
 rtl/uart_image_tx_sequencer.sv | 174 +++++++++++++++++
 tb/tb_uart_image_tx_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_image_tx_sequencer_pkg.sv
// Shared types and constants for the image-frame UART sequencer.
// Frame layout: sync bytes, 16-bit width/height, pixels, 8-bit checksum.
package uart_img_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  localparam logic [7:0] SYNC0     = 8'hAA;
  localparam logic [7:0] SYNC1     = 8'h55;
  localparam int         HDR_BYTES = 6;

endpackage

// File: rtl/uart_image_tx_sequencer.sv
// Streams one frame (header, pixels from a sync-read RAM, checksum) to a UART byte
// transmitter, one byte per start/busy transaction.
module uart_image_tx_sequencer
  import uart_img_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int NUM_PIX     = 4096,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum,
  output state_e            dbg_state
);

  // Handshake: tx_start is a one-cycle request with tx_data held stable; the
  // transmitter accepts by raising tx_busy the next cycle and finishes by dropping it.
  localparam int BIDX_W = ADDR_W + 2;
  localparam int PIX_W  = ADDR_W + 1;
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [BIDX_W-1:0] PIX_FIRST = BIDX_W'(HDR_BYTES);
  localparam logic [BIDX_W-1:0] LAST_IDX  = BIDX_W'(NUM_PIX + HDR_BYTES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [15:0]       IMG_W16   = 16'(IMG_W);
  localparam logic [15:0]       IMG_H16   = 16'(IMG_H);

  state_e              state_q, state_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [PIX_W-1:0]    pix_idx_q, pix_idx_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                abort_q, abort_d;
  logic                fetch_ph_q, fetch_ph_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [7:0]          csum_q, csum_d;
  logic [BIDX_W-1:0]   nxt_idx;
  logic [7:0]          hdr_byte;

  always_comb begin
    nxt_idx = byte_idx_q + BIDX_W'(1);
    case (nxt_idx[2:0])
      3'd1:    hdr_byte = SYNC1;
      3'd2:    hdr_byte = IMG_W16[15:8];
      3'd3:    hdr_byte = IMG_W16[7:0];
      3'd4:    hdr_byte = IMG_H16[15:8];
      3'd5:    hdr_byte = IMG_H16[7:0];
      default: hdr_byte = SYNC0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pix_idx_d  = pix_idx_q;
    to_d       = to_q;
    abort_d    = abort_q;
    fetch_ph_d = fetch_ph_q;
    mem_addr_d = mem_addr_q;
    tx_data_d  = tx_data_q;
    csum_d     = csum_q;
    tx_start   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    if (state_q != IDLE && abort) abort_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = ISSUE;
          byte_idx_d = '0;
          pix_idx_d  = '0;
          csum_d     = '0;
          tx_data_d  = SYNC0;
          abort_d    = 1'b0;
        end
      end
      FETCH: begin
        // Phase 0 presents the address; phase 1 sees the RAM data.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          tx_data_d  = mem_rdata;
          csum_d     = csum_q + mem_rdata;
          pix_idx_d  = pix_idx_q + PIX_W'(1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        to_d     = '0;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          err     = 1'b1;
          abort_d = 1'b0;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx_q == LAST_IDX) begin
            done    = 1'b1;
            abort_d = 1'b0;
            state_d = IDLE;
          end else if (abort_q) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            byte_idx_d = nxt_idx;
            if (nxt_idx >= PIX_FIRST && nxt_idx < LAST_IDX) begin
              mem_addr_d = ADDR_W'(pix_idx_q);
              state_d    = FETCH;
            end else begin
              tx_data_d = (nxt_idx == LAST_IDX) ? csum_q : hdr_byte;
              state_d   = ISSUE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      pix_idx_q  <= '0;
      to_q       <= '0;
      abort_q    <= 1'b0;
      fetch_ph_q <= 1'b0;
      mem_addr_q <= '0;
      tx_data_q  <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      pix_idx_q  <= pix_idx_d;
      to_q       <= to_d;
      abort_q    <= abort_d;
      fetch_ph_q <= fetch_ph_d;
      mem_addr_q <= mem_addr_d;
      tx_data_q  <= tx_data_d;
      csum_q     <= csum_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign tx_data   = tx_data_q;
  assign checksum  = csum_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_image_tx_sequencer.sv
// Bench for uart_image_tx_sequencer: RAM and transmitter models, a frame-level
// reference model compared every cycle, directed scenarios plus randomized frames.
module tb_uart_image_tx_sequencer;
  import uart_img_pkg::*;

  localparam int ADDR_W      = 16;
  localparam int IMG_W       = 2;
  localparam int IMG_H       = 2;
  localparam int NUM_PIX     = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int TX_CYC      = 20;
  localparam int FRAME_LEN   = NUM_PIX + 7;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        checksum;
  state_e            dbg_state;

  uart_image_tx_sequencer #(
    .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .NUM_PIX(NUM_PIX), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .done(done), .err(err), .checksum(checksum),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // sync-read frame RAM
  logic [7:0] ram [NUM_PIX];
  always @(posedge clk) mem_rdata <= ram[int'(mem_addr) % NUM_PIX];

  // transmitter: busy rises the cycle after tx_start and stays high TX_CYC cycles
  bit ack_en = 1'b1;
  int tx_cnt;
  always @(posedge clk) begin
    if (reset) begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end else if (tx_busy) begin
      if (tx_cnt == 1) tx_busy <= 1'b0;
      tx_cnt <= tx_cnt - 1;
    end else if (tx_start && ack_en) begin
      tx_busy <= 1'b1;
      tx_cnt  <= TX_CYC;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // frame-level reference model
  int   cyc = 0;
  bit   m_busy = 0, m_wait_ack = 0, m_abort = 0, m_hold_valid = 0, prev_txb = 0, prev_busy = 0;
  int   m_sent = 0, m_nxt_iss = -1, m_iss_cyc = 0;
  logic [7:0] m_sum = 8'h00;
  int   m_frames = 0, n_dut_frames = 0, n_done = 0, n_err = 0;
  int   last_txs_cyc = 0, last_err_cyc = 0;

  function automatic bit is_pix(input int idx);
    return (idx >= HDR_BYTES) && (idx < HDR_BYTES + NUM_PIX);
  endfunction

  always @(negedge clk) begin
    bit fall, last_done, abort_end, exp_err, exp_txs, mb_before;
    int sum;
    logic [7:0] exp_b;
    cyc++;
    if (reset) begin
      m_busy = 0; m_wait_ack = 0; m_abort = 0; prev_txb = 0; prev_busy = 0;
      m_hold_valid = 1; m_sum = 8'h00; m_nxt_iss = -1;
      exp_q.delete();
    end else begin
      fall      = m_busy && prev_txb && !tx_busy;
      last_done = fall && (m_sent == FRAME_LEN);
      abort_end = fall && !last_done && m_abort;
      exp_err   = m_busy && m_wait_ack && (cyc == m_iss_cyc + ACK_TIMEOUT);
      exp_txs   = m_busy && (cyc == m_nxt_iss);

      check("busy", busy, m_busy);
      check("tx_start", tx_start, exp_txs);
      check("done", done, last_done);
      check("err", err, exp_err);
      check("done_err_exclusive", done & err, 1'b0);

      if (tx_start) begin
        rx_log.push_back(tx_data);
        last_txs_cyc = cyc;
      end
      if (done) n_done++;
      if (err) begin
        n_err++;
        last_err_cyc = cyc;
      end
      if (busy && !prev_busy) n_dut_frames++;
      prev_busy = busy;

      if (exp_txs) begin
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("tx_data", tx_data, exp_b);
        end
        m_sent++;
        m_iss_cyc  = cyc;
        m_wait_ack = 1;
      end
      if (m_wait_ack && tx_busy) m_wait_ack = 0;
      if (last_done) check("checksum_at_done", checksum, m_sum);
      if (!m_busy && m_hold_valid) check("checksum_hold", checksum, m_sum);

      mb_before = m_busy;
      if (m_busy && abort) m_abort = 1;
      if (exp_err || last_done || abort_end) begin
        m_busy = 0; m_wait_ack = 0; m_abort = 0;
        m_hold_valid = last_done;
      end else if (fall) begin
        m_nxt_iss = cyc + (is_pix(m_sent) ? 3 : 1);
      end

      if (!mb_before && start && !abort) begin
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'((IMG_W >> 8) & 255));
        exp_q.push_back(8'(IMG_W & 255));
        exp_q.push_back(8'((IMG_H >> 8) & 255));
        exp_q.push_back(8'(IMG_H & 255));
        sum = 0;
        for (int i = 0; i < NUM_PIX; i++) begin
          exp_q.push_back(ram[i]);
          sum += int'(ram[i]);
        end
        m_sum = 8'(sum % 256);
        exp_q.push_back(m_sum);
        m_busy = 1; m_sent = 0; m_abort = 0; m_wait_ack = 0;
        m_nxt_iss = cyc + 1;
        m_hold_valid = 0;
        m_frames++;
      end
      prev_txb = tx_busy;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic set_ram(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    ram[0] = a; ram[1] = b; ram[2] = c; ram[3] = d;
  endtask

  task automatic wait_frame_end(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy) break;
      step();
    end
    check("frame_end_within_budget", busy, 1'b0);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (rx_log.size() >= n) break;
      step();
    end
    check("rx_count_reached", rx_log.size() >= n, 1'b1);
  endtask

  logic [7:0] lit1 [FRAME_LEN];
  int d0, e0, f0, g0;

  initial begin
    lit1 = '{8'hAA, 8'h55, 8'h00, 8'h02, 8'h00, 8'h02, 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h64};
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    set_ram(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) step();
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_checksum", checksum, 8'h00);
    reset = 1'b0;
    step();

    // reference frame
    set_ram(8'd10, 8'd20, 8'd30, 8'd40);
    rx_log.delete();
    d0 = n_done;
    pulse_start();
    wait_frame_end(2000);
    check("f1_len", rx_log.size(), FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++)
      if (i < rx_log.size()) check("f1_byte", rx_log[i], lit1[i]);
    check("f1_one_done", n_done - d0, 1);
    repeat (5) step();
    check("f1_busy_low_after", busy, 1'b0);

    // checksum wrap
    set_ram(8'hFF, 8'h02, 8'h00, 8'h00);
    rx_log.delete();
    pulse_start();
    wait_frame_end(2000);
    check("f2_checksum_port", checksum, 8'h01);
    if (rx_log.size() > 0) check("f2_checksum_byte", rx_log[rx_log.size()-1], 8'h01);
    repeat (10) step();
    check("f2_checksum_holds", checksum, 8'h01);

    // abort during pixel 1
    set_ram(8'd10, 8'd20, 8'd30, 8'd40);
    rx_log.delete();
    d0 = n_done;
    pulse_start();
    wait_rx(8, 2000);
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_frame_end(2000);
    repeat (30) step();
    check("abort_len", rx_log.size(), 8);
    if (rx_log.size() >= 8) check("abort_last_byte", rx_log[7], 8'h14);
    check("abort_no_done", n_done - d0, 0);
    check("abort_busy_low", busy, 1'b0);

    // ack timeout
    ack_en = 1'b0;
    e0 = n_err; d0 = n_done;
    pulse_start();
    wait_frame_end(500);
    check("to_one_err", n_err - e0, 1);
    check("to_latency", last_err_cyc - last_txs_cyc, ACK_TIMEOUT);
    check("to_no_done", n_done - d0, 0);
    ack_en = 1'b1;
    repeat (3) step();

    // start+abort together ignored, then start held through one frame
    f0 = m_frames; g0 = n_dut_frames;
    start = 1'b1; abort = 1'b1;
    step();
    abort = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done) break;
      step();
    end
    start = 1'b0;
    repeat (60) step();
    check("held_start_model_frames", m_frames - f0, 1);
    check("held_start_dut_frames", n_dut_frames - g0, 1);

    // reset during header byte 3
    rx_log.delete();
    pulse_start();
    wait_rx(4, 2000);
    repeat (5) step();
    check("pre_reset_state", dbg_state, WAIT_DONE);
    reset = 1'b1;
    step();
    check("mid_rst_tx_start", tx_start, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_mem_addr", mem_addr, 16'h0000);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_checksum", checksum, 8'h00);
    reset = 1'b0;
    step();
    rx_log.delete();
    set_ram(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    pulse_start();
    wait_frame_end(2000);
    check("post_reset_full_frame", rx_log.size(), FRAME_LEN);

    // randomized frames with occasional spurious start and abort
    for (int r = 0; r < 8; r++) begin
      set_ram(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 5)) step();
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, 50)) step();
        start = 1'b1;
        step();
        start = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 150)) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
      end
      wait_frame_end(2000);
    end
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
